// File: rtl/led_step_pkg.sv
// Shared types and constant helpers for the LED step controller.
package led_step_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN_R = 2'd1,
    S_RUN_L = 2'd2
  } state_t;

  localparam logic [1:0] DIR_R = 2'b10;
  localparam logic [1:0] DIR_L = 2'b01;

  // Cycles per step period; a rate at or above the clock collapses to one cycle.
  function automatic logic [31:0] step_div(input logic [31:0] clk_hz,
                                           input logic [31:0] step_hz,
                                           input logic [1:0]  spd);
    logic [31:0] rate;
    logic [31:0] div;
    rate = step_hz << spd;
    div  = (rate == 32'd0) ? clk_hz : clk_hz / rate;
    return (div < 32'd1) ? 32'd1 : div;
  endfunction

  function automatic logic [31:0] db_cycles(input logic [31:0] clk_hz,
                                            input logic [31:0] ms);
    logic [31:0] n;
    n = clk_hz / 32'd1000 * ms;
    return (n < 32'd1) ? 32'd1 : n;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-FF synchronizer followed by a stable-time debounce counter.
module sw_debounce #(
  parameter int unsigned DB_CYC = 1
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam int unsigned    CW   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DB_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any cycle where the input agrees with the accepted level restarts the wait.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/led_step_ctrl.sv
// Switch front end for the LED rotator: debounced direction FSM plus rate-limited step strobes.
// Optional build macro STEP_FIRST_EDGE_EN: emit a strobe immediately on entering a run state.
module led_step_ctrl
  import led_step_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned STEP_HZ     = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [1:0] iSW,
  input  logic [1:0] iSpeed,
  output logic [1:0] oSW,
  output logic       oBusy
);

  localparam int unsigned DB_CYC   = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned BASE_DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned CNT_W    = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  // Terminal counts for the four rates, folded to constants so no divider is built.
  localparam logic [CNT_W-1:0] LIM_0 = CNT_W'(step_div(CLK_HZ, STEP_HZ, 2'd0) - 32'd1);
  localparam logic [CNT_W-1:0] LIM_1 = CNT_W'(step_div(CLK_HZ, STEP_HZ, 2'd1) - 32'd1);
  localparam logic [CNT_W-1:0] LIM_2 = CNT_W'(step_div(CLK_HZ, STEP_HZ, 2'd2) - 32'd1);
  localparam logic [CNT_W-1:0] LIM_3 = CNT_W'(step_div(CLK_HZ, STEP_HZ, 2'd3) - 32'd1);

  logic [1:0]       w_db;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_lim;
  logic [1:0]       r_spd;
  logic [1:0]       r_osw;
  logic [1:0]       w_strobe;
  logic [1:0]       w_dir;
  logic             w_change;
  logic             w_wrap;

  sw_debounce #(.DB_CYC(DB_CYC)) u_db_r (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .i_raw  (iSW[1]),
    .o_db   (w_db[1])
  );

  sw_debounce #(.DB_CYC(DB_CYC)) u_db_l (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .i_raw  (iSW[0]),
    .o_db   (w_db[0])
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_db[1])      w_next = S_RUN_R;
        else if (w_db[0]) w_next = S_RUN_L;
      end
      S_RUN_R: begin
        if (!w_db[1]) w_next = w_db[0] ? S_RUN_L : S_IDLE;
      end
      S_RUN_L: begin
        if (w_db[1])       w_next = S_RUN_R;
        else if (!w_db[0]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_spd)
      2'd0:    w_lim = LIM_0;
      2'd1:    w_lim = LIM_1;
      2'd2:    w_lim = LIM_2;
      default: w_lim = LIM_3;
    endcase
  end

  assign w_change = (w_next != r_state);
  assign w_wrap   = (r_state != S_IDLE) && (r_cnt == w_lim);
  assign w_dir    = (r_state == S_RUN_R) ? DIR_R : DIR_L;

  // Back-to-back pulses would merge into a level, so a wrap right after a pulse is skipped.
  always_comb begin
    w_strobe = 2'b00;
    if (w_wrap && !w_change && (r_osw == 2'b00)) w_strobe = w_dir;
`ifdef STEP_FIRST_EDGE_EN
    if (w_change && (w_next != S_IDLE)) w_strobe = (w_next == S_RUN_R) ? DIR_R : DIR_L;
`else
`endif
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_spd   <= 2'd0;
      r_osw   <= 2'b00;
    end else begin
      r_state <= w_next;
      r_osw   <= w_strobe;
      // Rate is only sampled at period boundaries so a running period is never cut short.
      if (w_change || w_wrap) begin
        r_cnt <= '0;
        r_spd <= iSpeed;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign oSW   = r_osw;
  assign oBusy = (r_state != S_IDLE);

endmodule
